// File: rtl/merge_arb2.sv
// ============================================================================
//  Module      : merge_arb2
//  Description : Clocked 2-to-1 merge stage for the convergent path of the
//                tree NoC. Round-robin arbitration between two valid/ready
//                producers; winners are buffered in a small FIFO together
//                with a 1-bit source tag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module merge_arb2 #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [W-1:0]                 in0_data,
    input  logic                         in0_valid,
    output logic                         in0_ready,
    input  logic [W-1:0]                 in1_data,
    input  logic                         in1_valid,
    output logic                         in1_ready,
    output logic [W-1:0]                 out_data,
    output logic                         out_src,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Each entry holds {source tag, packet}
    logic [W:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          prio;      // input favoured when both producers contend

    logic          space;
    logic          grant;
    logic          acc0;
    logic          acc1;
    logic          push;
    logic          pop;

    // Grant selection and handshake decode; readies never look at out_ready
    always_comb begin
        space = (count < FULL_CNT);
        grant = 1'b0;
        if (in0_valid && in1_valid) begin
            grant = prio;
        end else if (in1_valid) begin
            grant = 1'b1;
        end
        in0_ready = ~reset & space & ~grant;
        in1_ready = ~reset & space &  grant;
        acc0      = in0_valid & in0_ready;
        acc1      = in1_valid & in1_ready;
        push      = acc0 | acc1;
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        {out_src, out_data} = mem[rd_ptr];
        occupancy = count;
    end

    // FIFO storage, pointers, occupancy and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= acc1 ? {1'b1, in1_data} : {1'b0, in0_data};
                wr_ptr      <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                // The loser of this acceptance is favoured next time
                prio        <= acc0;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_merge_arb2.sv
// ============================================================================
//  Module      : tb_merge_arb2
//  Description : Self-checking bench for merge_arb2 (table vectors plus
//                scoreboard-checked hand sequences).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_merge_arb2;

    localparam int W     = 9;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in0_data, in1_data, out_data;
    logic          in0_valid, in1_valid, in0_ready, in1_ready;
    logic          out_src, out_valid, out_ready;
    logic [CW-1:0] occupancy;

    merge_arb2 #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (rst),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state
    int          m_cnt = 0;
    bit          m_ptr = 1'b0;
    logic [W:0]  sb[$];
    logic [W:0]  seen[$];

    // Values sampled in the most recent cycle
    logic s_r0, s_r1, s_ov;
    int   s_occ;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then
    // advance the model across the rising edge.
    task automatic run_cycle(output bit a0, output bit a1);
        bit sp, g, er0, er1, popped;
        logic [W:0] head;
        @(negedge clk);
        sp  = !rst && (m_cnt < DEPTH);
        g   = (in0_valid && in1_valid) ? m_ptr : (in1_valid && !in0_valid);
        er0 = sp && !g;
        er1 = sp && g;
        s_r0 = in0_ready; s_r1 = in1_ready; s_ov = out_valid; s_occ = int'(occupancy);
        chk("in0_ready", int'(in0_ready), int'(er0));
        chk("in1_ready", int'(in1_ready), int'(er1));
        chk("occupancy", int'(occupancy), m_cnt);
        chk("out_valid", int'(out_valid), int'(m_cnt != 0));
        a0 = in0_valid && er0;
        a1 = in1_valid && er1;
        popped = 1'b0;
        if (!rst && m_cnt != 0 && out_ready && sb.size() > 0) begin
            head = sb.pop_front();
            chk("out_data", int'(out_data), int'(head[W-1:0]));
            chk("out_src", int'(out_src), int'(head[W]));
            seen.push_back({out_src, out_data});
            popped = 1'b1;
        end
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            m_ptr = 1'b0;
            sb.delete();
        end else begin
            if (a0) begin sb.push_back({1'b0, in0_data}); m_ptr = 1'b1; end
            if (a1) begin sb.push_back({1'b1, in1_data}); m_ptr = 1'b0; end
            m_cnt = m_cnt + int'(a0 || a1) - int'(popped);
        end
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       v0;
        logic [8:0] d0;
        logic       v1;
        logic [8:0] d1;
        logic       ordy;
        logic       e_r0;
        logic       e_r1;
        logic       e_ov;
        int         e_occ;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        bit a0, a1;
        int n0, n1, nseen;
        logic [W:0] exp_order [8];

        // rst v0 d0 v1 d1 ordy | r0 r1 ov occ
        tbl[0]  = '{1'b1, 1'b1, 9'h011, 1'b1, 9'h021, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b1, 9'h011, 1'b1, 9'h021, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b1, 9'h011, 1'b1, 9'h021, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 9'h011, 1'b1, 9'h021, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 9'h012, 1'b1, 9'h021, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b0, 1'b1, 9'h012, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[6]  = '{1'b0, 1'b1, 9'h012, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[7]  = '{1'b0, 1'b1, 9'h012, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[8]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 9'h0A1, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 1'b1, 9'h0A2, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[13] = '{1'b0, 1'b1, 9'h0A3, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[14] = '{1'b0, 1'b1, 9'h0A3, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[15] = '{1'b0, 1'b1, 9'h0A3, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        tbl[16] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        tbl[17] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1};
        tbl[18] = '{1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b1; out_ready = 1'b0;
        in0_valid = 1'b0; in0_data = '0; in1_valid = 1'b0; in1_data = '0;

        // Reset hold, mixed contention and backpressure/full vectors
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; in0_valid = tbl[i].v0; in0_data = tbl[i].d0;
            in1_valid = tbl[i].v1; in1_data = tbl[i].d1; out_ready = tbl[i].ordy;
            run_cycle(a0, a1);
            chk($sformatf("tbl%0d_in0_ready", i), int'(s_r0), int'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_in1_ready", i), int'(s_r1), int'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_out_valid", i), int'(s_ov), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_occupancy", i), s_occ, tbl[i].e_occ);
        end

        // Single stream from in1: 0x1A3 then 0x0F5, one-cycle latency
        in0_valid = 1'b0; out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 9'h1A3;
        run_cycle(a0, a1);
        chk("single_acc_1a3", int'(a1), 1);
        in1_data = 9'h0F5;
        run_cycle(a0, a1);
        chk("single_ov_after_1a3", int'(s_ov), 1);
        in1_valid = 1'b0;
        run_cycle(a0, a1);
        chk("single_ov_after_0f5", int'(s_ov), 1);
        run_cycle(a0, a1);
        chk("single_drained", int'(s_ov), 0);

        // Contention round-robin with out_ready high; start from a clean pointer
        rst = 1'b1;
        run_cycle(a0, a1);
        rst = 1'b0;
        nseen = seen.size();
        n0 = 0; n1 = 0;
        for (int c = 0; c < 30; c++) begin
            in0_valid = (n0 < 4); in0_data = 9'h100 + 9'(n0);
            in1_valid = (n1 < 4); in1_data = 9'h020 + 9'(n1);
            if (n0 >= 4 && n1 >= 4 && sb.size() == 0) break;
            run_cycle(a0, a1);
            if (a0) n0++;
            if (a1) n1++;
        end
        exp_order[0] = {1'b0, 9'h100}; exp_order[1] = {1'b1, 9'h020};
        exp_order[2] = {1'b0, 9'h101}; exp_order[3] = {1'b1, 9'h021};
        exp_order[4] = {1'b0, 9'h102}; exp_order[5] = {1'b1, 9'h022};
        exp_order[6] = {1'b0, 9'h103}; exp_order[7] = {1'b1, 9'h023};
        chk("rr_count", seen.size() - nseen, 8);
        for (int k = 0; k < 8; k++) begin
            if (nseen + k < seen.size())
                chk($sformatf("rr_order%0d", k), int'(seen[nseen + k]), int'(exp_order[k]));
        end

        // Steady-state push/pop at occupancy 1, through pointer wrap
        in1_valid = 1'b0; out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 9'h0C0;
        run_cycle(a0, a1);
        out_ready = 1'b1;
        n0 = 1;
        for (int c = 0; c < 10; c++) begin
            in0_data = 9'h0C0 + 9'(n0);
            run_cycle(a0, a1);
            chk($sformatf("steady_occ%0d", c), s_occ, 1);
            if (a0) n0++;
        end
        in0_valid = 1'b0;
        run_cycle(a0, a1);
        run_cycle(a0, a1);

        // Mid-traffic reset with two buffered packets
        out_ready = 1'b0; in0_valid = 1'b1; in0_data = 9'h0B1;
        run_cycle(a0, a1);
        in0_data = 9'h0B2;
        run_cycle(a0, a1);
        in0_valid = 1'b0;
        run_cycle(a0, a1);
        chk("pre_reset_occ", s_occ, 2);
        nseen = seen.size();
        rst = 1'b1;
        run_cycle(a0, a1);
        rst = 1'b0; out_ready = 1'b1;
        run_cycle(a0, a1);
        chk("post_reset_valid", int'(s_ov), 0);
        for (int c = 0; c < 3; c++) run_cycle(a0, a1);
        chk("post_reset_no_emit", seen.size() - nseen, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/merge_arb2.md
Name: merge_arb2

Overview:
- Clocked 2-to-1 merge stage of the tree NoC. Sits directly downstream of the two-way address decoder's output ports on the upward/convergent path.
- Takes 9-bit packets from two producers: bits [8:4:?]: [8:5] = 4-bit destination address, [4:0] = 5-bit payload.
- Arbitrates between the producers round-robin and buffers winners in a small FIFO. Emits one packet stream plus a 1-bit source tag, which is the counterpart of the decoder's S select.

Parameters:
- W, 9, packet width in bits (address in [W-1:W-4]); carried through untouched.
- DEPTH, 2, output FIFO entries; legal values 2..8.

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in0_data  input  W  packet from producer 0
- in0_valid  input  1  producer 0 offers a packet
- in0_ready  output  1  packet on in0 accepted this cycle when in0_valid & in0_ready
- in1_data  input  W  packet from producer 1
- in1_valid  input  1  producer 1 offers a packet
- in1_ready  output  1  as in0_ready, for in1
- out_data  output  W  head-of-FIFO packet
- out_src  output  1  input index the head packet came from (0/1)
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer takes head when out_valid & out_ready
- occupancy  output  $clog2(DEPTH+1)  current FIFO entry count

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on reset; it is sampled only at the rising edge.
- Reset values: out_valid=0, out_data=0, out_src=0, occupancy=0, priority pointer=0 (in0 favoured). FIFO read/write pointers=0.
- Reset mid-operation: all buffered packets are discarded. in0_ready and in1_ready are 0 while reset is high.
- Handshake rules:
  - Valid/ready per channel; a transfer occurs on a cycle where both are high at the rising edge.
  - A producer holds valid and data stable until accepted.
  - The consumer may drop out_ready at any time.
- space = (occupancy < DEPTH). The readies never depend on out_ready; there is no pass-through when full.
- Grant, combinational from valids, pointer and space:
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant the input equal to the pointer.
  - in_i_ready = space & (grant==i).
  - At most one input is accepted per cycle; the non-granted ready is 0 even if its valid is high.
- Pointer update: on any acceptance from input i, the pointer becomes 1-i, so the loser of contention wins next. No acceptance means the pointer holds.
- FIFO write: an accepted packet is written with {src=i, data} at the write pointer. Pointers wrap modulo DEPTH.
- Latency: a packet accepted in cycle N gives out_valid=1 from cycle N+1, when the FIFO was empty. Order is strictly FIFO.
- Simultaneous push and pop:
  - Allowed whenever space is 1; occupancy is unchanged.
  - When full, pop only: occupancy becomes DEPTH-1 and readies reassert the next cycle.
- Throughput: with DEPTH>=2 and out_ready tied high, one packet per cycle is sustained.
- Empty: out_valid=0. out_data/out_src hold the last dequeued values and are don't-care for checking.
- occupancy tracks the entry count exactly: +1 on push, -1 on pop, unchanged on both or neither.
- Data is never modified. Address bits are not interpreted by this block.
- Fairness bound: under continuous contention each input is accepted within 2 acceptances.

Test Plan:
- Reset hold:
  - Stimulus: reset=1 for 3 cycles with in0/in1 valid.
  - Required response: readies=0, out_valid=0, occupancy=0. The first cycle after release grants in0.
- Single stream:
  - Stimulus: in1 only sends 0x1A3, then 0x0F5; out_ready=1.
  - Required response: out 0x1A3 src=1 at N+1, then 0x0F5 src=1 at N+2.
- Contention round-robin:
  - Stimulus: in0 holds 0x100..0x103 and in1 holds 0x020..0x023, both continuously valid; out_ready=1.
  - Required response: output alternates 0x100(0), 0x020(1), 0x101(0), 0x021(1), ...
- Backpressure/full:
  - Stimulus: out_ready=0 and in0 sends 3 packets.
  - Required response: 2 accepted, occupancy=2, in0_ready=0 on the 3rd. Raise out_ready for 1 cycle: the first packet pops, occupancy=1, and the 3rd is accepted the next cycle.
- Simultaneous push/pop at steady state:
  - Stimulus: occupancy=1, in0 valid and out_ready=1 for 10 cycles.
  - Required response: occupancy stays 1, and order is preserved through pointer wrap.
- Mid-traffic reset:
  - Stimulus: reset for 1 cycle with occupancy=2.
  - Required response: out_valid=0 the next cycle, and the buffered packets are never emitted.
